qk_seq_controller: RTL

QK_SEQ_CONTROLLER -- requirements
Module: qk_seq_controller

---
 rtl/qk_seq_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/qk_seq_controller.sv
// Q/K attention tile sequencer: walks Q/K SRAM writes, MAC load/execute, PMEM
// accumulation, optional row normalization and final readout, one strobe set per cycle.
module qk_seq_controller #(
  parameter int ADDR_W   = 4,
  parameter int Q_DEPTH  = 16,
  parameter int K_DEPTH  = 8,
  parameter int P_DEPTH  = 8,
  parameter int HOLD_CYC = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [3:0]        num_tiles,
  input  logic              ld_done,
  input  logic              exec_done,
  input  logic              out_wr,
  input  logic              abort,
  output logic [ADDR_W-1:0] qk_add,
  output logic [ADDR_W-1:0] p_add,
  output logic              q_wr,
  output logic              k_wr,
  output logic              q_rd,
  output logic              k_rd,
  output logic              load,
  output logic              execute,
  output logic              ofifo_rd,
  output logic              p_wr,
  output logic              p_rd,
  output logic              sfp_acc,
  output logic              sfp_div,
  output logic              busy,
  output logic              done,
  output logic              op_valid,
  output logic              error
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, Q_WR, K_WR, K_LD, LD_HOLD, EXEC, OF_HOLD, P_WR, NORM, OUT, ERR
  } state_t;

  typedef struct packed {
    logic q_wr, k_wr, q_rd, k_rd, load, execute, ofifo_rd, p_wr, p_rd, sfp_acc, sfp_div;
    logic busy, op_valid, error;
  } ctl_t;

  state_t            state, nstate;
  logic [ADDR_W-1:0] idx, nidx;
  logic [1:0]        ph, nph;
  logic [HOLD_W-1:0] hcnt, nhcnt;
  logic [WAIT_W-1:0] wcnt, nwcnt;
  logic [3:0]        tile, ntile, nt_r, nnt, nt_eff;
  logic [1:0]        mode_r, nmode;
  logic              wait_hit, tile_last;

  ctl_t              ctl_q, ctl_d;
  logic [ADDR_W-1:0] qk_q, qk_d, p_q, p_d;

  assign wait_hit  = (wcnt == WAIT_W'(TIMEOUT - 1));
  assign nt_eff    = (nt_r == 4'd0) ? 4'd1 : nt_r;
  assign tile_last = (tile == nt_eff - 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      ph     <= '0;
      hcnt   <= '0;
      wcnt   <= '0;
      tile   <= '0;
      nt_r   <= '0;
      mode_r <= '0;
    end else begin
      state  <= nstate;
      idx    <= nidx;
      ph     <= nph;
      hcnt   <= nhcnt;
      wcnt   <= nwcnt;
      tile   <= ntile;
      nt_r   <= nnt;
      mode_r <= nmode;
    end
  end

  always_comb begin
    nstate = state;
    nidx   = idx;
    nph    = ph;
    nhcnt  = hcnt;
    nwcnt  = wcnt;
    ntile  = tile;
    nnt    = nt_r;
    nmode  = mode_r;
    unique case (state)
      IDLE: if (start) begin
        nstate = Q_WR;
        nmode  = mode;
        nnt    = num_tiles;
        ntile  = '0;
        nidx   = '0;
      end
      Q_WR: if (idx == ADDR_W'(Q_DEPTH - 1)) begin
        nstate = K_WR;
        nidx   = '0;
      end else nidx = idx + 1'b1;
      K_WR: if (idx == ADDR_W'(K_DEPTH - 1)) begin
        nstate = K_LD;
        nidx   = '0;
        nwcnt  = '0;
      end else nidx = idx + 1'b1;
      K_LD: if (ld_done) begin
        nstate = LD_HOLD;
        nhcnt  = '0;
      end else if (wait_hit) nstate = ERR;
      else begin
        nwcnt = wcnt + 1'b1;
        if (idx != ADDR_W'(K_DEPTH - 1)) nidx = idx + 1'b1;
      end
      LD_HOLD: if (hcnt == HOLD_W'(HOLD_CYC - 1)) begin
        nstate = EXEC;
        nidx   = '0;
        nwcnt  = '0;
      end else nhcnt = hcnt + 1'b1;
      EXEC: if (exec_done) begin
        nstate = OF_HOLD;
        nwcnt  = '0;
      end else if (wait_hit) nstate = ERR;
      else begin
        nwcnt = wcnt + 1'b1;
        nidx  = (idx == ADDR_W'(Q_DEPTH - 1)) ? '0 : idx + 1'b1;
      end
      OF_HOLD: if (out_wr) begin
        nstate = P_WR;
        nidx   = '0;
      end else if (wait_hit) nstate = ERR;
      else nwcnt = wcnt + 1'b1;
      P_WR: if (idx == ADDR_W'(P_DEPTH - 1)) begin
        nidx = '0;
        nph  = '0;
        if (!tile_last) begin
          ntile  = tile + 4'd1;
          nstate = mode_r[1] ? K_WR : Q_WR;
        end else nstate = mode_r[0] ? NORM : OUT;
      end else nidx = idx + 1'b1;
      // Four sub-phases per PMEM row; the row index advances after the write-back phase.
      NORM: begin
        nph = ph + 2'd1;
        if (ph == 2'd3) begin
          if (idx == ADDR_W'(P_DEPTH - 1)) begin
            nstate = OUT;
            nidx   = '0;
          end else nidx = idx + 1'b1;
        end
      end
      OUT: if (idx == ADDR_W'(P_DEPTH - 1)) begin
        nstate = IDLE;
        nidx   = '0;
      end else nidx = idx + 1'b1;
      ERR: ;
      default: nstate = IDLE;
    endcase
    if (abort) begin
      nstate = IDLE;
      nidx   = '0;
      nph    = '0;
      nhcnt  = '0;
      nwcnt  = '0;
      ntile  = '0;
      nnt    = '0;
      nmode  = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  always_comb begin
    ctl_d = '0;
    qk_d  = '0;
    p_d   = '0;
    unique case (nstate)
      Q_WR:    begin ctl_d.q_wr = 1'b1; qk_d = nidx; end
      K_WR:    begin ctl_d.k_wr = 1'b1; qk_d = nidx; end
      K_LD:    begin ctl_d.k_rd = 1'b1; ctl_d.load = 1'b1; qk_d = nidx; end
      EXEC:    begin ctl_d.execute = 1'b1; ctl_d.q_rd = 1'b1; qk_d = nidx; end
      P_WR:    begin ctl_d.ofifo_rd = 1'b1; ctl_d.p_wr = 1'b1; p_d = nidx; end
      NORM: begin
        p_d = nidx;
        unique case (nph)
          2'd0: ctl_d.p_rd    = 1'b1;
          2'd1: ctl_d.sfp_acc = 1'b1;
          2'd2: ctl_d.sfp_div = 1'b1;
          2'd3: ctl_d.p_wr    = 1'b1;
        endcase
      end
      OUT:     begin ctl_d.p_rd = 1'b1; ctl_d.op_valid = 1'b1; p_d = nidx; end
      ERR:     ctl_d.error = 1'b1;
      default: ;
    endcase
    ctl_d.busy = (nstate != IDLE) && (nstate != ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q <= '0;
      qk_q  <= '0;
      p_q   <= '0;
    end else begin
      ctl_q <= ctl_d;
      qk_q  <= qk_d;
      p_q   <= p_d;
    end
  end

  assign qk_add   = qk_q;
  assign p_add    = p_q;
  assign q_wr     = ctl_q.q_wr;
  assign k_wr     = ctl_q.k_wr;
  assign q_rd     = ctl_q.q_rd;
  assign k_rd     = ctl_q.k_rd;
  assign load     = ctl_q.load;
  assign execute  = ctl_q.execute;
  assign ofifo_rd = ctl_q.ofifo_rd;
  assign p_wr     = ctl_q.p_wr;
  assign p_rd     = ctl_q.p_rd;
  assign sfp_acc  = ctl_q.sfp_acc;
  assign sfp_div  = ctl_q.sfp_div;
  assign busy     = ctl_q.busy;
  assign op_valid = ctl_q.op_valid;
  assign error    = ctl_q.error;
  assign done     = (state == IDLE);

endmodule
